// File: rtl/fft_pkg.sv
// Shared constants and helpers for the 8-point FFT datapath and its input framer.
package fft_pkg;

    localparam int FFT_N      = 8;
    localparam int FFT_LOG2N  = 3;
    localparam int FFT_DATA_W = 8;

    localparam logic [FFT_LOG2N-1:0] FFT_LAST_IDX = FFT_LOG2N'(FFT_N - 1);

    function automatic logic [FFT_LOG2N-1:0] bitrev3(input logic [FFT_LOG2N-1:0] k);
        return {k[0], k[1], k[2]};
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One ping-pong bank of the FFT input framer: 8 complex slots plus a full flag.
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [FFT_LOG2N-1:0]    addr,
    input  logic [DATA_W-1:0]       wr_real,
    input  logic [DATA_W-1:0]       wr_imag,
    input  logic                    set_full,
    input  logic                    clr_full,
    output logic                    full,
    output logic [FFT_N*DATA_W-1:0] real_frame,
    output logic [FFT_N*DATA_W-1:0] imag_frame
);

    logic [DATA_W-1:0] slot_real [FFT_N];
    logic [DATA_W-1:0] slot_imag [FFT_N];

    // NOTE: the slot array carries a reset so the frame buses read 0 straight out of reset;
    // state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FFT_N; i++) begin
                slot_real[i] <= '0;
                slot_imag[i] <= '0;
            end
        end else if (we) begin
            slot_real[addr] <= wr_real;
            slot_imag[addr] <= wr_imag;
        end
    end

    // set and clear never coincide: set needs an empty bank, clear needs a full one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        full <= 1'b0;
        else if (set_full) full <= 1'b1;
        else if (clr_full) full <= 1'b0;
    end

    // NOTE: outputs get a default before the loop so no latch is inferred.
    always_comb begin
        real_frame = '0;
        imag_frame = '0;
        for (int i = 0; i < FFT_N; i++) begin
            real_frame[DATA_W*i +: DATA_W] = slot_real[i];
            imag_frame[DATA_W*i +: DATA_W] = slot_imag[i];
        end
    end

endmodule

// File: rtl/fft_input_framer.sv
// Serial-to-frame ping-pong buffer feeding fft_8_point.
// Define FFT_FRAMER_BITREV_EN to store frames in bit-reversed slot order.
module fft_input_framer
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_real,
    input  logic [DATA_W-1:0]       in_imag,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic [FFT_N*DATA_W-1:0] real_frame,
    output logic [FFT_N*DATA_W-1:0] imag_frame,
    output logic [3:0]              fill_level
);

    logic                    wr_sel;
    logic                    rd_sel;
    logic [FFT_LOG2N-1:0]    wr_cnt;
    logic [FFT_LOG2N-1:0]    slot_addr;
    logic [1:0]              bank_full;
    logic [1:0]              wr_onehot;
    logic [1:0]              rd_onehot;
    logic                    accept;
    logic                    last_accept;
    logic                    consume;
    logic [FFT_N*DATA_W-1:0] bank_real [2];
    logic [FFT_N*DATA_W-1:0] bank_imag [2];

`ifdef FFT_FRAMER_BITREV_EN
    assign slot_addr = bitrev3(wr_cnt);
`else
    assign slot_addr = wr_cnt;
`endif

    // in_ready depends only on registered state and flush, never on frame_ready
    assign in_ready    = !bank_full[wr_sel] && !flush;
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (wr_cnt == FFT_LAST_IDX);
    assign frame_valid = bank_full[rd_sel];
    assign consume     = frame_valid && frame_ready;
    assign fill_level  = {1'b0, wr_cnt};
    assign wr_onehot   = {wr_sel, !wr_sel};
    assign rd_onehot   = {rd_sel, !rd_sel};
    assign real_frame  = bank_real[rd_sel];
    assign imag_frame  = bank_imag[rd_sel];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_frame_bank #(
            .DATA_W (DATA_W)
        ) u_bank (
            .clk        (clk),
            .rst_n      (rst_n),
            .we         (accept && wr_onehot[b]),
            .addr       (slot_addr),
            .wr_real    (in_real),
            .wr_imag    (in_imag),
            .set_full   (last_accept && wr_onehot[b]),
            .clr_full   (consume && rd_onehot[b]),
            .full       (bank_full[b]),
            .real_frame (bank_real[b]),
            .imag_frame (bank_imag[b])
        );
    end

    // flush and accept are exclusive because flush forces in_ready low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt <= '0;
            wr_sel <= 1'b0;
        end else if (flush) begin
            wr_cnt <= '0;
        end else if (last_accept) begin
            wr_cnt <= '0;
            wr_sel <= !wr_sel;
        end else if (accept) begin
            wr_cnt <= wr_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       rd_sel <= 1'b0;
        else if (consume) rd_sel <= !rd_sel;
    end

endmodule

// File: tb/tb_fft_input_framer.sv
// Directed bench for fft_input_framer with a frame scoreboard and per-cycle handshake model.
module tb_fft_input_framer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_real;
    logic [7:0]  in_imag;
    logic        frame_valid;
    logic        frame_ready;
    logic [63:0] real_frame;
    logic [63:0] imag_frame;
    logic [3:0]  fill_level;

    typedef struct {
        logic [63:0] re;
        logic [63:0] im;
    } frame_t;

    frame_t exp_q[$];
    frame_t cur;
    int     cnt   = 0;
    int     seq   = 1;
    int     total = 0;
    int     bad   = 0;

`ifdef FFT_FRAMER_BITREV_EN
    localparam logic [63:0] EXP1 = 64'h0804_0602_0703_0501;
`else
    localparam logic [63:0] EXP1 = 64'h0807_0605_0403_0201;
`endif

    fft_input_framer #(.DATA_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_real     (in_real),
        .in_imag     (in_imag),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .real_frame  (real_frame),
        .imag_frame  (imag_frame),
        .fill_level  (fill_level)
    );

    always #5 clk = ~clk;

    function automatic int tb_map(input int k);
`ifdef FFT_FRAMER_BITREV_EN
        return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
`else
        return k;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at posedge+1, check and update the model at negedge.
    task automatic cycle(input logic v, input logic [7:0] re, input logic [7:0] im,
                         input logic fr, input logic fl);
        logic exp_rdy;
        logic exp_fv;
        in_valid    = v;
        in_real     = re;
        in_imag     = im;
        frame_ready = fr;
        flush       = fl;
        @(negedge clk);
        exp_rdy = !fl && (exp_q.size() < 2);
        exp_fv  = (exp_q.size() != 0);
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        check("frame_valid", 64'(frame_valid), 64'(exp_fv));
        check("fill_level", 64'(fill_level), 64'(cnt));
        if (exp_fv) begin
            check("frame_real", real_frame, exp_q[0].re);
            check("frame_imag", imag_frame, exp_q[0].im);
            if (fr) void'(exp_q.pop_front());
        end
        if (fl) begin
            cnt = 0;
        end else if (v && exp_rdy) begin
            cur.re[8*tb_map(cnt) +: 8] = re;
            cur.im[8*tb_map(cnt) +: 8] = im;
            if (cnt == 7) begin
                exp_q.push_back(cur);
                cnt = 0;
            end else begin
                cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input int n, input logic fr);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 8'(seq), ~8'(seq), fr, 1'b0);
            seq++;
        end
    endtask

    task automatic idle(input int n, input logic fr);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 8'h00, fr, 1'b0);
    endtask

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_real     = '0;
        in_imag     = '0;
        frame_ready = 1'b0;
        cur.re      = '0;
        cur.im      = '0;
        #3;
        check("rst_frame_valid", 64'(frame_valid), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_fill_level", 64'(fill_level), 64'(0));
        check("rst_real_frame", real_frame, 64'(0));
        check("rst_imag_frame", imag_frame, 64'(0));
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ramp frame, consumed at once
        for (int k = 0; k < 8; k++) cycle(1'b1, 8'(k + 1), 8'h00, 1'b1, 1'b0);
        check("t1_latency_valid", 64'(frame_valid), 64'(1));
        check("t1_real_order", real_frame, EXP1);
        check("t1_imag_zero", imag_frame, 64'(0));
        idle(2, 1'b1);

        // back-to-back frames with no stalls
        stream(16, 1'b1);
        idle(2, 1'b1);

        // backpressure: both banks fill, first frame held
        stream(16, 1'b0);
        check("bp_ready_low", 64'(in_ready), 64'(0));
        stream(3, 1'b0);
        cycle(1'b1, 8'hA5, 8'h5A, 1'b1, 1'b0);
        check("bp_ready_back", 64'(in_ready), 64'(1));
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        idle(2, 1'b1);
        idle(8, 1'b1);

        // flush mid-frame
        stream(7, 1'b1);
        stream(1, 1'b1);
        stream(5, 1'b1);
        cycle(1'b1, 8'hEE, 8'hEE, 1'b1, 1'b1);
        check("flush_fill_zero", 64'(fill_level), 64'(0));
        stream(8, 1'b1);
        idle(2, 1'b1);

        // asynchronous reset mid-frame with a frame pending
        stream(8, 1'b0);
        stream(3, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("arst_frame_valid", 64'(frame_valid), 64'(0));
        check("arst_in_ready", 64'(in_ready), 64'(1));
        check("arst_fill_level", 64'(fill_level), 64'(0));
        check("arst_real_frame", real_frame, 64'(0));
        exp_q.delete();
        cnt = 0;
        #1 rst_n = 1'b1;

        // B1 completes in the same cycle B0 is consumed
        stream(8, 1'b0);
        stream(7, 1'b0);
        cycle(1'b1, 8'(seq), ~8'(seq), 1'b1, 1'b0);
        seq++;
        check("sim_frame_valid", 64'(frame_valid), 64'(1));
        idle(3, 1'b1);

        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
